// File: rtl/div_array_seq_ctrl.sv
// Round-robin sequencer for a shared combinational 16/8 array divider: arbitrates two
// requesters, holds operands for a settle window, and returns a tagged result.
// Optional macro DIV_SEQ_CTRL_STATS_EN adds saturating op/dz/ovf counters and stat_clr.
module div_array_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_n0,
  input  logic [7:0]  req_d0,
  input  logic [15:0] req_n1,
  input  logic [7:0]  req_d1,
  output logic [15:0] div_n,
  output logic [7:0]  div_d,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [7:0]  resp_q,
  output logic [7:0]  resp_r,
  output logic        resp_dz,
  output logic        resp_ovf,
  output logic        busy
`ifdef DIV_SEQ_CTRL_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_ops,
  output logic [7:0]  stat_dz,
  output logic [7:0]  stat_ovf
`endif
);

  localparam int unsigned N_W   = 16;
  localparam int unsigned D_W   = 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rr_ptr, w_rr_nxt;
  logic [N_W-1:0]   r_div_n, w_div_n_nxt;
  logic [D_W-1:0]   r_div_d, w_div_d_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_id, w_id_nxt;
  logic [D_W-1:0]   r_q, w_q_nxt;
  logic [D_W-1:0]   r_r, w_r_nxt;
  logic             r_dz, w_dz_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_ovf_pend, w_ovf_pend_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_gnt;
  logic             w_accept;
  logic [N_W-1:0]   w_sel_n;
  logic [D_W-1:0]   w_sel_d;
  logic             w_dz;
  logic             w_ovf;
  logic             w_handshake;

  // Round-robin grant: pointer requester first, otherwise the other one
  assign w_gnt     = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_accept  = (r_state == S_IDLE) && (|req_valid);
  assign req_ready = {w_gnt, ~w_gnt} & {2{w_accept}};
  assign w_sel_n   = w_gnt ? req_n1 : req_n0;
  assign w_sel_d   = w_gnt ? req_d1 : req_d0;
  assign w_dz      = (w_sel_d == '0);
  assign w_ovf     = (w_sel_n[15:8] >= w_sel_d) && !w_dz;
  assign w_handshake = (r_state == S_RESP) && resp_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rr_nxt       = r_rr_ptr;
    w_div_n_nxt    = r_div_n;
    w_div_d_nxt    = r_div_d;
    w_valid_nxt    = r_valid;
    w_id_nxt       = r_id;
    w_q_nxt        = r_q;
    w_r_nxt        = r_r;
    w_dz_nxt       = r_dz;
    w_ovf_nxt      = r_ovf;
    w_ovf_pend_nxt = r_ovf_pend;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_div_n_nxt    = w_sel_n;
          w_div_d_nxt    = w_sel_d;
          w_id_nxt       = w_gnt;
          w_rr_nxt       = ~w_gnt;
          w_ovf_pend_nxt = w_ovf;
          if (w_dz) begin
            // Divider output is meaningless for d==0; answer immediately
            w_state_nxt = S_RESP;
            w_valid_nxt = 1'b1;
            w_q_nxt     = 8'hFF;
            w_r_nxt     = w_sel_n[7:0];
            w_dz_nxt    = 1'b1;
            w_ovf_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_q_nxt     = div_q;
          w_r_nxt     = div_r;
          w_ovf_nxt   = r_ovf_pend;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_valid_nxt = 1'b0;
          w_dz_nxt    = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= 1'b0;
      r_div_n    <= '0;
      r_div_d    <= '0;
      r_valid    <= 1'b0;
      r_id       <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_div_n    <= w_div_n_nxt;
      r_div_d    <= w_div_d_nxt;
      r_valid    <= w_valid_nxt;
      r_id       <= w_id_nxt;
      r_q        <= w_q_nxt;
      r_r        <= w_r_nxt;
      r_dz       <= w_dz_nxt;
      r_ovf      <= w_ovf_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign div_n      = r_div_n;
  assign div_d      = r_div_d;
  assign resp_valid = r_valid;
  assign resp_id    = r_id;
  assign resp_q     = r_q;
  assign resp_r     = r_r;
  assign resp_dz    = r_dz;
  assign resp_ovf   = r_ovf;
  assign busy       = r_busy;

`ifdef DIV_SEQ_CTRL_STATS_EN
  logic [15:0] r_stat_ops;
  logic [7:0]  r_stat_dz;
  logic [7:0]  r_stat_ovf;

  // Saturating event counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ops <= '0;
      r_stat_dz  <= '0;
      r_stat_ovf <= '0;
    end else if (stat_clr) begin
      r_stat_ops <= '0;
      r_stat_dz  <= '0;
      r_stat_ovf <= '0;
    end else if (w_handshake) begin
      if (r_stat_ops != '1)          r_stat_ops <= r_stat_ops + 16'd1;
      if (r_dz && (r_stat_dz != '1))   r_stat_dz  <= r_stat_dz + 8'd1;
      if (r_ovf && (r_stat_ovf != '1)) r_stat_ovf <= r_stat_ovf + 8'd1;
    end
  end

  assign stat_ops = r_stat_ops;
  assign stat_dz  = r_stat_dz;
  assign stat_ovf = r_stat_ovf;
`else
  logic w_unused;
  assign w_unused = w_handshake;
`endif

endmodule

// File: tb/tb_div_array_seq_ctrl.sv
// Directed bench for div_array_seq_ctrl with an exact behavioural divider on div_*.
module tb_div_array_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_n0, req_n1;
  logic [7:0]  req_d0, req_d1;
  logic [15:0] div_n;
  logic [7:0]  div_d, div_q, div_r;
  logic        resp_valid, resp_ready, resp_id, resp_dz, resp_ovf, busy;
  logic [7:0]  resp_q, resp_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Exact array-divider model: truncated 8-bit quotient, as the raw hardware would give
  always_comb begin
    div_q = 8'h00;
    div_r = 8'h00;
    if (div_d != 8'h00) begin
      div_q = 8'(div_n / {8'h00, div_d});
      div_r = 8'(div_n % {8'h00, div_d});
    end
  end

  div_array_seq_ctrl #(.SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n0(req_n0), .req_d0(req_d0), .req_n1(req_n1), .req_d1(req_d1),
    .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz), .resp_ovf(resp_ovf),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_div_n"}, 32'(div_n), 32'h0);
    chk({tag, "_div_d"}, 32'(div_d), 32'h0);
    chk({tag, "_flags"}, 32'({resp_valid, resp_id, resp_dz, resp_ovf, busy}), 32'h0);
    chk({tag, "_qr"}, 32'({resp_q, resp_r}), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_resp(input string tag);
    int cyc = 0;
    while (!resp_valid && cyc < 12) begin
      tick();
      cyc++;
    end
    chk({tag, "_resp_timeout"}, 32'(resp_valid), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
    req_n0 = 16'h0; req_d0 = 8'h0; req_n1 = 16'h0; req_d1 = 8'h0;
    tick();
    chk_reset_outputs("reset");
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single op 1000/7 from requester 0, latency 3
    req_n0 = 16'd1000; req_d0 = 8'd7; req_valid = 2'b01;
    #1;
    chk("op1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("op1_operands", 32'({div_n, div_d}), 32'({16'd1000, 8'd7}));
    chk("op1_busy_T", 32'({busy, resp_valid}), 32'h2);
    tick();
    chk("op1_valid_T1", 32'(resp_valid), 32'h0);
    tick();
    chk("op1_valid_T2", 32'(resp_valid), 32'h0);
    tick();
    chk("op1_valid_T3", 32'(resp_valid), 32'h1);
    chk("op1_qr", 32'({resp_q, resp_r}), 32'({8'd142, 8'd6}));
    chk("op1_id_dz_ovf", 32'({resp_id, resp_dz, resp_ovf}), 32'h0);
    tick();
    chk("op1_done", 32'({resp_valid, busy}), 32'h0);
    chk("op1_div_n_held", 32'(div_n), 32'd1000);

    // Divide by zero from requester 1
    req_n1 = 16'h1234; req_d1 = 8'h00; req_valid = 2'b10;
    #1;
    chk("dz_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    chk("dz_valid_T1", 32'(resp_valid), 32'h1);
    chk("dz_qr", 32'({resp_q, resp_r}), 32'h0000FF34);
    chk("dz_flags", 32'({resp_id, resp_dz, resp_ovf}), 32'h6);
    tick();
    chk("dz_cleared", 32'({resp_valid, resp_dz}), 32'h0);

    // Overflow: 0x0500/4 = 320, raw truncated quotient 0x40 rem 0
    req_n0 = 16'h0500; req_d0 = 8'd4; req_valid = 2'b01;
    #1;
    chk("ovf_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();
    chk("ovf_valid", 32'(resp_valid), 32'h1);
    chk("ovf_flags", 32'({resp_dz, resp_ovf}), 32'h1);
    chk("ovf_qr", 32'({resp_q, resp_r}), 32'h00004000);
    chk("ovf_raw_q", 32'(resp_q), 32'(div_q));
    tick();
    chk("ovf_cleared", 32'({resp_valid, resp_ovf}), 32'h0);

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    req_n0 = 16'd100; req_d0 = 8'd3; req_n1 = 16'd200; req_d1 = 8'd9;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int cyc = 0;
      #1;
      while (req_ready == 2'b00 && cyc < 12) begin
        tick();
        cyc++;
      end
      chk($sformatf("cont%0d_grant", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      wait_resp($sformatf("cont%0d", k));
      chk($sformatf("cont%0d_id", k), 32'(resp_id), 32'(k % 2));
      chk($sformatf("cont%0d_qr", k), 32'({resp_q, resp_r}),
          (k % 2 == 0) ? 32'({8'd33, 8'd1}) : 32'({8'd22, 8'd2}));
      tick();
    end
    req_valid = 2'b00;

    // Backpressure: result held, no grants while RESP waits
    resp_ready = 1'b0;
    req_n0 = 16'd1000; req_d0 = 8'd7; req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    wait_resp("bp");
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_hold", c), 32'({resp_valid, resp_id, resp_q, resp_r}),
          32'({1'b1, 1'b0, 8'd142, 8'd6}));
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_released", 32'({resp_valid, req_ready}), 32'h2);
    req_valid = 2'b00;
    tick();
    chk("bp_idle", 32'(busy), 32'h0);

    // Reset one cycle after accept discards the operation
    req_n0 = 16'd1000; req_d0 = 8'd7; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("midrst_noresp%0d", c), 32'({resp_valid, busy}), 32'h0);
    end
    req_n1 = 16'd200; req_d1 = 8'd9; req_valid = 2'b10;
    #1;
    chk("midrst_fresh_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    wait_resp("midrst_fresh");
    chk("midrst_fresh_res", 32'({resp_id, resp_q, resp_r}), 32'({1'b1, 8'd22, 8'd2}));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
